// File: rtl/div_unit_if.sv
// div_unit_if: EXE-stage <-> divider handshake bundle.
// master = EXE stage (issues DIV/DIVU), slave = div_unit.
// Optional abort line div_annul exists only when DIV_ANNUL_EN is defined.
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
`ifdef DIV_ANNUL_EN
    logic              div_annul;
`endif
    logic [DATA_W-1:0] div_lo;
    logic [DATA_W-1:0] div_hi;
    logic              div_ready;
    logic              stallreq_exe;

`ifdef DIV_ANNUL_EN
    modport master (
        output div_start, div_signed, dividend, divisor, div_annul,
        input  div_lo, div_hi, div_ready, stallreq_exe
    );
    modport slave (
        input  div_start, div_signed, dividend, divisor, div_annul,
        output div_lo, div_hi, div_ready, stallreq_exe
    );
`else
    modport master (
        output div_start, div_signed, dividend, divisor,
        input  div_lo, div_hi, div_ready, stallreq_exe
    );
    modport slave (
        input  div_start, div_signed, dividend, divisor,
        output div_lo, div_hi, div_ready, stallreq_exe
    );
`endif
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Quotient -> div_lo, remainder -> div_hi. Raises stallreq_exe while a
// requested division is not finished.
// Optional feature macro: DIV_ANNUL_EN (adds div_annul abort input).
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic       cpu_clk_50M,
    input  logic       cpu_rst,
    div_unit_if.slave  div_bus
);
    localparam int   CNT_W  = $clog2(DATA_W);
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg,   state_next;
    logic [CNT_W-1:0]    cnt_reg,     cnt_next;
    logic [2*DATA_W:0]   work_reg,    work_next;   // {remainder[32:0], quotient[31:0]}
    logic [DATA_W-1:0]   dvsr_reg,    dvsr_next;   // |divisor|
    logic [DATA_W-1:0]   dvnd_reg,    dvnd_next;   // dividend as presented (for /0)
    logic                neg_q_reg,   neg_q_next;
    logic                neg_r_reg,   neg_r_next;
    logic [DATA_W-1:0]   lo_reg,      lo_next;
    logic [DATA_W-1:0]   hi_reg,      hi_next;

    logic                annul;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W+1:0]   trial;
    logic [2*DATA_W:0]   step_work;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;

`ifdef DIV_ANNUL_EN
    assign annul = div_bus.div_annul;
`else
    assign annul = 1'b0;
`endif

    // Operand conditioning: magnitudes are only taken for signed divides.
    assign a_neg = div_bus.div_signed & div_bus.dividend[DATA_W-1];
    assign b_neg = div_bus.div_signed & div_bus.divisor[DATA_W-1];
    assign abs_a = a_neg ? (~div_bus.dividend + 1'b1) : div_bus.dividend;
    assign abs_b = b_neg ? (~div_bus.divisor + 1'b1) : div_bus.divisor;

    // One restoring step: shift left, trial-subtract from the upper part.
    // The extra top bit of the trial difference is the borrow (negative).
    assign trial     = work_reg[2*DATA_W:DATA_W-1] - {2'b00, dvsr_reg};
    assign step_work = trial[DATA_W+1]
                     ? {work_reg[2*DATA_W-1:0], 1'b0}
                     : {trial[DATA_W:0], work_reg[DATA_W-2:0], 1'b1};
    assign quot      = step_work[DATA_W-1:0];
    assign rem       = step_work[2*DATA_W-1:DATA_W];

    // Next-state and datapath update; annul overrides everything.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        work_next  = work_reg;
        dvsr_next  = dvsr_reg;
        dvnd_next  = dvnd_reg;
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;

        if (annul) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (div_bus.div_start) begin
                        dvnd_next  = div_bus.dividend;
                        dvsr_next  = abs_b;
                        neg_r_next = a_neg;
                        neg_q_next = a_neg ^ b_neg;
                        work_next  = {{(DATA_W+1){1'b0}}, abs_a};
                        cnt_next   = '0;
                        state_next = (div_bus.divisor == '0) ? ZERO : BUSY;
                    end
                end
                BUSY: begin
                    work_next = step_work;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(DATA_W - 1)) begin
                        // Sign fix-up: quotient truncates toward zero,
                        // remainder follows the dividend's sign.
                        lo_next    = neg_q_reg ? (~quot + 1'b1) : quot;
                        hi_next    = neg_r_reg ? (~rem + 1'b1) : rem;
                        state_next = DONE;
                    end
                end
                ZERO: begin
                    lo_next    = '1;
                    hi_next    = dvnd_reg;
                    state_next = DONE;
                end
                DONE: begin
                    if (!div_bus.div_start) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            work_reg  <= '0;
            dvsr_reg  <= '0;
            dvnd_reg  <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            lo_reg    <= '0;
            hi_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            work_reg  <= work_next;
            dvsr_reg  <= dvsr_next;
            dvnd_reg  <= dvnd_next;
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
        end
    end

    assign div_bus.div_lo       = lo_reg;
    assign div_bus.div_hi       = hi_reg;
    assign div_bus.div_ready    = (state_reg == DONE);
    assign div_bus.stallreq_exe = (div_bus.div_start && (state_reg != DONE)
                                   && !cpu_rst && !annul) ? STOP : NOSTOP;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Build with +define+DIV_ANNUL_EN to also exercise the annul input.
module tb_div_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .div_bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one division and wait (bounded) for div_ready; div_start is left
    // high on exit. Operands are scrambled after T0 to prove they are latched.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int rdy_cyc, output int stall_cyc,
                           output logic stall_at_rdy);
        @(negedge clk);
        bus.div_signed = s;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_start  = 1'b1;
        rdy_cyc        = -1;
        stall_cyc      = 0;
        stall_at_rdy   = 1'bx;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (bus.div_ready) begin
                rdy_cyc      = i;
                stall_at_rdy = bus.stallreq_exe;
                break;
            end
            if (bus.stallreq_exe) stall_cyc++;
            @(negedge clk);
            bus.dividend   = ~a;
            bus.divisor    = b + 32'd3;
            bus.div_signed = ~s;
        end
    endtask

    // Drop div_start and let the unit settle back into IDLE.
    task automatic finish_div();
        @(negedge clk);
        bus.div_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.div_start = 1'b1;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.stallreq_exe !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stallreq_exe); end
        checks++; if (bus.div_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.div_ready); end
        checks++; if (bus.div_lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.div_hi); end
        bus.div_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: ready=%b lo=%h hi=%h", bus.div_ready, bus.div_lo, bus.div_hi);
    endtask

    task automatic test_unsigned();
        int rc, sc; logic sr;
        run_div(1'b0, 32'd100, 32'd7, rc, sc, sr);
        $display("divu 100/7: ready@T%0d stalls=%0d lo=%h hi=%h", rc, sc, bus.div_lo, bus.div_hi);
        checks++; if (rc !== 33) begin errors++; $display("FAIL unsigned_latency: got T%0d want T33", rc); end
        checks++; if (sc !== 33) begin errors++; $display("FAIL unsigned_stalls: got %0d want 33", sc); end
        checks++; if (sr !== 1'b0) begin errors++; $display("FAIL unsigned_stall_done: got %b want 0", sr); end
        checks++; if (bus.div_lo !== 32'd14) begin errors++; $display("FAIL unsigned_lo: got %h want %h", bus.div_lo, 32'd14); end
        checks++; if (bus.div_hi !== 32'd2) begin errors++; $display("FAIL unsigned_hi: got %h want %h", bus.div_hi, 32'd2); end
        finish_div();
    endtask

    task automatic test_signed();
        int rc, sc; logic sr;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, rc, sc, sr);
        $display("div -7/2: ready@T%0d lo=%h hi=%h", rc, bus.div_lo, bus.div_hi);
        checks++; if (bus.div_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL signed1_lo: got %h want fffffffd", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed1_hi: got %h want ffffffff", bus.div_hi); end
        finish_div();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, rc, sc, sr);
        $display("div 7/-2: ready@T%0d lo=%h hi=%h", rc, bus.div_lo, bus.div_hi);
        checks++; if (bus.div_lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL signed2_lo: got %h want fffffffd", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'h0000_0001) begin errors++; $display("FAIL signed2_hi: got %h want 00000001", bus.div_hi); end
        finish_div();
    endtask

    task automatic test_overflow();
        int rc, sc; logic sr;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, rc, sc, sr);
        $display("div min/-1: ready@T%0d lo=%h hi=%h", rc, bus.div_lo, bus.div_hi);
        checks++; if (bus.div_lo !== 32'h8000_0000) begin errors++; $display("FAIL overflow_lo: got %h want 80000000", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'h0) begin errors++; $display("FAIL overflow_hi: got %h want 0", bus.div_hi); end
        finish_div();
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, rc, sc, sr);
        $display("divu max/1: ready@T%0d lo=%h hi=%h", rc, bus.div_lo, bus.div_hi);
        checks++; if (bus.div_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL extreme_lo: got %h want ffffffff", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'h0) begin errors++; $display("FAIL extreme_hi: got %h want 0", bus.div_hi); end
        finish_div();
    endtask

    task automatic test_div_zero();
        int rc, sc; logic sr;
        run_div(1'b0, 32'h0000_1234, 32'd0, rc, sc, sr);
        $display("divu 0x1234/0: ready@T%0d stalls=%0d lo=%h hi=%h", rc, sc, bus.div_lo, bus.div_hi);
        checks++; if (rc !== 2) begin errors++; $display("FAIL zero_latency: got T%0d want T2", rc); end
        checks++; if (sc !== 2) begin errors++; $display("FAIL zero_stalls: got %0d want 2", sc); end
        checks++; if (bus.div_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_lo: got %h want ffffffff", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'h0000_1234) begin errors++; $display("FAIL zero_hi: got %h want 00001234", bus.div_hi); end
        finish_div();
    endtask

    task automatic test_reset_midop();
        int rc, sc; logic sr;
        @(negedge clk);
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd1000;
        bus.divisor    = 32'd3;
        bus.div_start  = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.stallreq_exe !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", bus.stallreq_exe); end
        @(negedge clk);
        rst = 1'b0;
        bus.div_start = 1'b0;
        #1;
        $display("reset at T10: ready=%b lo=%h hi=%h", bus.div_ready, bus.div_lo, bus.div_hi);
        checks++; if (bus.div_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", bus.div_ready); end
        checks++; if (bus.div_lo !== 32'h0) begin errors++; $display("FAIL midrst_lo: got %h want 0", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'h0) begin errors++; $display("FAIL midrst_hi: got %h want 0", bus.div_hi); end
        run_div(1'b0, 32'd9, 32'd3, rc, sc, sr);
        $display("divu 9/3 after reset: ready@T%0d lo=%h hi=%h", rc, bus.div_lo, bus.div_hi);
        checks++; if (rc !== 33) begin errors++; $display("FAIL fresh_latency: got T%0d want T33", rc); end
        checks++; if (bus.div_lo !== 32'd3) begin errors++; $display("FAIL fresh_lo: got %h want 3", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'd0) begin errors++; $display("FAIL fresh_hi: got %h want 0", bus.div_hi); end
        finish_div();
    endtask

    task automatic test_back_to_back();
        int rc, sc; logic sr;
        run_div(1'b0, 32'd50, 32'd5, rc, sc, sr);
        $display("divu 50/5: ready@T%0d lo=%h hi=%h", rc, bus.div_lo, bus.div_hi);
        checks++; if (bus.div_lo !== 32'd10) begin errors++; $display("FAIL b2b1_lo: got %h want a", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'd0) begin errors++; $display("FAIL b2b1_hi: got %h want 0", bus.div_hi); end
        finish_div();
        run_div(1'b0, 32'd51, 32'd5, rc, sc, sr);
        $display("divu 51/5: ready@T%0d lo=%h hi=%h", rc, bus.div_lo, bus.div_hi);
        checks++; if (rc !== 33) begin errors++; $display("FAIL b2b2_latency: got T%0d want T33", rc); end
        checks++; if (bus.div_lo !== 32'd10) begin errors++; $display("FAIL b2b2_lo: got %h want a", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'd1) begin errors++; $display("FAIL b2b2_hi: got %h want 1", bus.div_hi); end
        finish_div();
    endtask

    // div_start falls mid-division: the unit still finishes, pulses ready
    // once and never requests a stall.
    task automatic test_flush();
        int pulses, stalls;
        pulses = 0;
        stalls = 0;
        @(negedge clk);
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd20;
        bus.divisor    = 32'd6;
        bus.div_start  = 1'b1;
        repeat (5) @(negedge clk);
        bus.div_start = 1'b0;
        for (int i = 0; i < 45; i++) begin
            #1;
            if (bus.div_ready) pulses++;
            if (bus.stallreq_exe) stalls++;
            @(negedge clk);
        end
        $display("flush 20/6: ready pulses=%0d stalls=%0d lo=%h hi=%h", pulses, stalls, bus.div_lo, bus.div_hi);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL flush_pulses: got %0d want 1", pulses); end
        checks++; if (stalls !== 0) begin errors++; $display("FAIL flush_stalls: got %0d want 0", stalls); end
        checks++; if (bus.div_lo !== 32'd3) begin errors++; $display("FAIL flush_lo: got %h want 3", bus.div_lo); end
        checks++; if (bus.div_hi !== 32'd2) begin errors++; $display("FAIL flush_hi: got %h want 2", bus.div_hi); end
    endtask

`ifdef DIV_ANNUL_EN
    task automatic test_annul();
        logic [31:0] lo_keep, hi_keep;
        int pulses;
        lo_keep = bus.div_lo;
        hi_keep = bus.div_hi;
        pulses  = 0;
        @(negedge clk);
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd100;
        bus.divisor    = 32'd7;
        bus.div_start  = 1'b1;
        repeat (5) @(negedge clk);
        bus.div_annul = 1'b1;
        #1;
        checks++; if (bus.stallreq_exe !== 1'b0) begin errors++; $display("FAIL annul_stall: got %b want 0", bus.stallreq_exe); end
        @(negedge clk);
        bus.div_annul = 1'b0;
        bus.div_start = 1'b0;
        #1;
        checks++; if (bus.div_ready !== 1'b0) begin errors++; $display("FAIL annul_ready: got %b want 0", bus.div_ready); end
        // Annul together with start in IDLE must not launch a division.
        @(negedge clk);
        bus.div_annul = 1'b1;
        bus.div_start = 1'b1;
        #1;
        checks++; if (bus.stallreq_exe !== 1'b0) begin errors++; $display("FAIL annul_idle_stall: got %b want 0", bus.stallreq_exe); end
        @(negedge clk);
        bus.div_annul = 1'b0;
        bus.div_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.div_ready) pulses++;
            @(negedge clk);
        end
        $display("annul at T5: ready pulses=%0d lo=%h hi=%h", pulses, bus.div_lo, bus.div_hi);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL annul_pulses: got %0d want 0", pulses); end
        checks++; if (bus.div_lo !== lo_keep) begin errors++; $display("FAIL annul_lo: got %h want %h", bus.div_lo, lo_keep); end
        checks++; if (bus.div_hi !== hi_keep) begin errors++; $display("FAIL annul_hi: got %h want %h", bus.div_hi, hi_keep); end
    endtask
`endif

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'h0;
        bus.divisor    = 32'h0;
`ifdef DIV_ANNUL_EN
        bus.div_annul  = 1'b0;
`endif
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_div_zero();
        test_reset_midop();
        test_back_to_back();
        test_flush();
`ifdef DIV_ANNUL_EN
        test_annul();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the EXE stage, serving DIV and DIVU. It is the requester side of the pipeline stall handshake: while a division is in flight it drives `stallreq_exe` to the stall control unit, which freezes PC/IF/ID/EXE until the result is ready. It uses a radix-2 restoring algorithm with one quotient bit per cycle, writing the quotient to LO and the remainder to HI.

## Interface
Parameters:
- `DATA_W`, default 32: operand and result width. Only 32 is supported.

Ports:
- `cpu_clk_50M`  in  1  core clock; all state updates on its rising edge.
- `cpu_rst`  in  1  reset, synchronous, active-high.
- `div_start`  in  1  EXE holds a DIV/DIVU. It must stay high until `div_ready` is observed.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with the operands.
- `dividend`  in  32  rs operand. Sampled on the start cycle only.
- `divisor`  in  32  rt operand. Sampled on the start cycle only.
- `div_annul`  in  1  abort the current division. Present only with `DIV_ANNUL_EN`.
- `div_lo`  out  32  quotient. Valid while `div_ready` is high.
- `div_hi`  out  32  remainder. Valid while `div_ready` is high.
- `div_ready`  out  1  result valid.
- `stallreq_exe`  out  1  `STOP` while `div_start` is high and the unit is not in DONE; `NOSTOP` otherwise. Combinational from the state register and `div_start`.

## Operation
The unit has four states: IDLE, ZERO, BUSY and DONE.
- **IDLE**, when `div_start` is high:
  - Latch the absolute values of the operands (absolute only if `div_signed`), the sign of the dividend, and the XOR of the operand signs.
  - Go to ZERO if `divisor` is 0, otherwise go to BUSY with `cnt` = 0.
- **BUSY**:
  - Working register is 65 bits: {remainder[32:0], quotient[31:0]}.
  - Each cycle, shift left by 1 and trial-subtract the divisor from the upper 33 bits.
  - If the trial result is non-negative, keep it and set quotient bit 0 to 1. Otherwise restore and set it to 0.
  - `cnt` increments each cycle. After the iteration with `cnt` = 31, go to DONE.
- **Post-fix** on the BUSY→DONE transition, when `div_signed` is set:
  - Negate the quotient if the operand signs differed.
  - Negate the remainder if the dividend was negative.
  - The remainder therefore takes the sign of the dividend, and the quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no trap.
- **ZERO**: go to DONE with LO = 0xFFFFFFFF and HI = the original dividend (unmodified, signed or not).
- **DONE**:
  - `div_ready` = 1 and the results are held.
  - When `div_start` drops, go to IDLE.
  - If `div_start` is still high, stay in DONE. No new division starts until `div_start` has been low for at least one cycle in IDLE.
- **Outputs outside DONE**: `div_lo` and `div_hi` hold their last value. `div_ready` = 0.
- **Reset** (`cpu_rst` = 1, any state, including mid-division):
  - Next edge: state goes to IDLE; `cnt`, working register, `div_lo` and `div_hi` clear to 0; `div_ready` goes to 0.
  - `stallreq_exe` is `NOSTOP` during reset.

## Timing
- The start cycle is T0: `div_start` is high in IDLE. `stallreq_exe` = `STOP` already in T0.
- Normal division: BUSY during T1–T32, `div_ready` = 1 and `stallreq_exe` = `NOSTOP` in T33. This gives 33 stall cycles.
- Divide by zero: ZERO at T1, `div_ready` at T2.
- Back-to-back divisions: the instruction leaves EXE after T33, so `div_start` falls. The earliest next start is in IDLE, two cycles after DONE.
- Operand changes after T0 have no effect on the result.
- `div_start` dropping in BUSY or ZERO (pipeline flush without annul):
  - The division completes internally and the unit passes through DONE for one cycle.
  - `div_ready` pulses but is ignored.
  - `stallreq_exe` stays `NOSTOP`, because `div_start` is low.

## Configuration
- `DIV_ANNUL_EN` defined:
  - The `div_annul` port exists.
  - `div_annul` = 1 in any state sends the unit to IDLE on the next edge, with `div_ready` = 0.
  - `div_lo` and `div_hi` are not updated. `stallreq_exe` is forced to `NOSTOP` in the same cycle.
  - If `div_annul` and `div_start` are both high in IDLE, annul wins and no division starts.
- `DIV_ANNUL_EN` undefined:
  - There is no `div_annul` port.
  - An abort happens only through `div_start` falling, as described under Timing.

## Test plan
- **Unsigned:** DIVU 100 / 7 → `stallreq_exe` = `STOP` for T0–T32; at T33 `div_ready` = 1, LO = 14, HI = 2.
- **Signed:** DIV 0xFFFFFFF9 (−7) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → LO = 0xFFFFFFFD, HI = 1.
- **Overflow and extreme:** DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. DIVU 0xFFFFFFFF / 1 → LO = 0xFFFFFFFF, HI = 0.
- **Divide by zero:** DIVU 0x1234 / 0 → `div_ready` at T2, LO = 0xFFFFFFFF, HI = 0x1234, 2 stall cycles.
- **Reset mid-op:** assert `cpu_rst` at T10 of a DIVU → next cycle IDLE, LO = HI = 0, `div_ready` = 0. A fresh DIVU 9 / 3 then gives LO = 3, HI = 0 at T33.
- **Annul and back-to-back:**
  - With `DIV_ANNUL_EN`, pulse `div_annul` at T5 → IDLE at T6, LO/HI unchanged, `stallreq_exe` low at T5.
  - DIVU 50 / 5 then DIVU 51 / 5 back to back → second result LO = 10, HI = 1, with no corruption from the first.
